// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier scheduler.
//   state_t    : controller states (IDLE, RUN, DONE)
//   booth_op_t : radix-2 Booth operation selected by an adjacent bit pair
//   booth_decode() maps the pair {acc[1], acc[0]} to the operation.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration.
//   acc_in  [2*WIDTH+1:0] : {upper[WIDTH:0], multiplier/low bits[WIDTH-1:0], q_-1}
//   a_ext   [WIDTH:0]     : multiplicand sign-extended to WIDTH+1 bits
//   acc_out [2*WIDTH+1:0] : accumulator after add/sub and arithmetic right shift
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] acc_in,
  input  logic [WIDTH:0]     a_ext,
  output logic [2*WIDTH+1:0] acc_out
);

  booth_op_t        op;
  logic [WIDTH:0]   upper;

  always_comb begin
    op    = booth_decode(acc_in[1:0]);
    upper = acc_in[2*WIDTH+1:WIDTH+1];
    case (op)
      ADD:     upper = upper + a_ext;
      SUB:     upper = upper - a_ext;
      default: upper = acc_in[2*WIDTH+1:WIDTH+1];
    endcase
    // Arithmetic shift right by one: replicate the new upper sign bit.
    acc_out = {upper[WIDTH], upper, acc_in[WIDTH:1]};
  end

endmodule

// File: rtl/booth_mul_sched.sv
// Two-requester signed Booth multiplier with round-robin arbitration.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    : request handshake for requester N (0/1)
//   reqN_a, reqN_b [WIDTH]     : signed multiplicand / multiplier
//   rsp_valid / rsp_ready      : response handshake
//   rsp_id                     : requester that owns the product
//   rsp_product [2*WIDTH]      : signed product a*b
//   busy                       : high whenever not IDLE
// One multiplication takes WIDTH cycles after the accept edge.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 busy
);

  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned ACCW = 2 * WIDTH + 2;

  state_t               state_q, state_d;
  logic                 ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [ACCW-1:0]      acc_q, acc_step;
  logic [WIDTH:0]       a_q;
  logic                 rsp_valid_q;
  logic                 rsp_id_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic                 grant0, grant1;
  logic                 last_step;
  logic [WIDTH-1:0]     a_sel, b_sel;

  // Pointer gives priority on contention; a lone requester always wins.
  assign grant0    = req0_valid & (~ptr_q | ~req1_valid);
  assign grant1    = req1_valid & ( ptr_q | ~req0_valid);
  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign a_sel     = req1_ready ? req1_a : req0_a;
  assign b_sel     = req1_ready ? req1_b : req0_b;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_q),
    .a_ext   (a_q),
    .acc_out (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Readies are gated by rst_n so they read 0 throughout reset.
        req0_ready = rst_n & grant0;
        req1_ready = rst_n & grant1;
        if (req0_ready | req1_ready) state_d = RUN;
      end
      RUN: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (rsp_valid_q & rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      prod_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            acc_q    <= {{(WIDTH + 1){1'b0}}, b_sel, 1'b0};
            a_q      <= {a_sel[WIDTH-1], a_sel};
            rsp_id_q <= req1_ready;
            cnt_q    <= '0;
            ptr_q    <= req0_ready;
          end
        end
        RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            rsp_valid_q <= 1'b1;
            prod_q      <= acc_step[2*WIDTH:1];
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = prod_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mul_sched.sv
module tb_booth_mul_sched;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
  logic            rsp_valid, rsp_ready, rsp_id, busy;
  logic [2*W-1:0]  rsp_product;

  typedef struct {
    logic           id;
    logic [2*W-1:0] prod;
    int             acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  booth_mul_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Scoreboard: push on observed accept, check latency on rise, pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (req0_valid && req0_ready) begin
        sb.push_back('{1'b0, model(req0_a, req0_b), cyc + 1});
        acc_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1'b1, model(req1_a, req1_b), cyc + 1});
        acc_log.push_back(1);
      end
      if (rsp_valid && !prev_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=1 product=%h, required no response", rsp_product);
        end else if (cyc - sb[0].acc_cyc != W) begin
          n_fail++;
          $display("FAIL latency: got %0d cycles, required %0d", cyc - sb[0].acc_cyc, W);
        end
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (rsp_product !== e.prod || rsp_id !== e.id) begin
          n_fail++;
          $display("FAIL rsp_data: product=%h id=%0b, required product=%h id=%0b",
                   rsp_product, rsp_id, e.prod, e.id);
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) ok = 1;
    end
    @(posedge clk); #1;
    // Drop valid and scramble operands: result must depend on latched values only.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: requester %0d not accepted, required accept", id);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid && !busy) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: pending=%0d busy=%0b, required pending=0 busy=0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 1; req0_b = 1; req1_a = 1; req1_b = 1;
    #3;
    n_checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, busy} !== 5'b0 || rsp_product !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b%b valid=%b id=%b busy=%b prod=%h, required all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, busy, rsp_product);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    issue(0, 3, 5);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_run: busy=%b, required 1", busy);
    end
    wait_idle();
    n_checks++;
    if (rsp_product !== 64'd15) begin
      n_fail++;
      $display("FAIL basic_hold: product=%h, required %h", rsp_product, 64'd15);
    end
    issue(1, -7, 6);
    wait_idle();
    n_checks++;
    if (rsp_product !== 64'hFFFF_FFFF_FFFF_FFD6 || rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_hold: product=%h id=%b, required FFFFFFFFFFFFFFD6 id=1", rsp_product, rsp_id);
    end
  endtask

  task automatic test_corner();
    rsp_ready = 1'b1;
    issue(0, 32'h8000_0000, 32'h8000_0000);
    wait_idle();
    n_checks++;
    if (rsp_product !== 64'h4000_0000_0000_0000) begin
      n_fail++;
      $display("FAIL min_sq: product=%h, required 4000000000000000", rsp_product);
    end
    issue(1, 32'h8000_0000, 32'h1);
    wait_idle();
    n_checks++;
    if (rsp_product !== 64'hFFFF_FFFF_8000_0000) begin
      n_fail++;
      $display("FAIL min_x1: product=%h, required FFFFFFFF80000000", rsp_product);
    end
    issue(0, 32'h7FFF_FFFF, 32'h8000_0000);
    issue(1, $urandom, $urandom);
    issue(0, $urandom, $urandom);
    wait_idle();
  endtask

  task automatic test_round_robin();
    bit got4 = 0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    sb.delete(); acc_log.delete();
    req0_valid = 1'b1; req0_a = 11;   req0_b = -3;
    req1_valid = 1'b1; req1_a = -100; req1_b = 77;
    #2;
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_reset_ready: rdy=%b%b, required 00", req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400 && !got4; i++) begin
      @(posedge clk); #1;
      if (acc_log.size() >= 4) got4 = 1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (acc_log.size() <= i || acc_log[i] != (i % 2)) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d, required %0d", i,
                 (acc_log.size() > i) ? acc_log[i] : -1, i % 2);
      end
    end
    do_reset();
    acc_log.delete();
    issue(1, 9, -9);
    wait_idle();
    n_checks++;
    if (acc_log.size() != 1 || acc_log[0] != 1) begin
      n_fail++;
      $display("FAIL lone_req1: accepts=%0d first=%0d, required 1 accept from 1",
               acc_log.size(), (acc_log.size() > 0) ? acc_log[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    logic [2*W-1:0] p0;
    logic id0;
    rsp_ready = 1'b0;
    issue(1, -12345, 678);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_timeout: rsp_valid=0, required 1");
    end
    p0 = rsp_product; id0 = rsp_id;
    n_checks++;
    if (p0 !== model(-12345, 678) || id0 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: product=%h id=%b, required %h id=1", p0, id0, model(-12345, 678));
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_product !== p0 || rsp_id !== id0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stable[%0d]: valid=%b prod=%h id=%b rdy=%b%b busy=%b, required 1 %h %b 00 1",
                 i, rsp_valid, rsp_product, rsp_id, req0_ready, req1_ready, busy, p0, id0);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hs_ready: rdy=%b%b, required 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_product !== p0) begin
      n_fail++;
      $display("FAIL bp_after: valid=%b busy=%b prod=%h, required 0 0 %h", rsp_valid, busy, rsp_product, p0);
    end
  endtask

  task automatic test_reset_mid_run();
    bit stray = 0;
    rsp_ready = 1'b1;
    issue(0, 1234, -99);
    repeat (16) @(posedge clk);
    #1;
    req0_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, busy} !== 5'b0 || rsp_product !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b%b valid=%b id=%b busy=%b prod=%h, required all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, busy, rsp_product);
    end
    sb.delete();
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) stray = 1;
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL abort_no_rsp: response or busy after aborted run, required none");
    end
    issue(0, 2, 3);
    wait_idle();
    n_checks++;
    if (rsp_product !== 64'd6) begin
      n_fail++;
      $display("FAIL post_reset: product=%h, required %h", rsp_product, 64'd6);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_sched.md
BOOTH_MUL_SCHED -- requirements
Module: booth_mul_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  requester 0/1 has an operand pair pending.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1 each  requester 0/1 request accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  signed two's-complement multiplicand (a) and multiplier (b).
REQ-007 SHALL have port rsp_valid  output  1  product available.
REQ-008 SHALL have port rsp_ready  input  1  consumer takes product.
REQ-009 SHALL have port rsp_id  output  1  requester that owns the product.
REQ-010 SHALL have port rsp_product  output  2*WIDTH  signed product a*b.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accept; RUN->DONE when step count reaches WIDTH; DONE->IDLE on rsp_valid & rsp_ready.
REQ-013 SHALL assert reqN_ready only in IDLE and only for the granted requester, combinationally from reqN_valid and the grant pointer; accept means reqN_valid & reqN_ready.
REQ-014 SHALL arbitrate round-robin: the priority pointer starts at 0 and, after each accept, points to the non-accepted requester; a lone valid requester is granted regardless of the pointer.
REQ-015 SHALL at the accept edge load the accumulator with {(WIDTH+1) zeros, b, 1'b0}, latch a sign-extended to WIDTH+1 bits, latch the requester id into rsp_id, and clear the step counter.
REQ-016 SHALL in each RUN cycle perform one radix-2 Booth step on the pair (acc[1], acc[0]): 01 adds a to the upper WIDTH+1 bits, 10 subtracts a, 00/11 adds nothing; then shift the whole accumulator arithmetically right by 1 and increment the counter.
REQ-017 SHALL use a WIDTH+1-bit upper accumulator so that a = -2^(WIDTH-1) yields the exact product without overflow.
REQ-018 SHALL assert rsp_valid from the clock edge that completes step WIDTH, i.e. exactly WIDTH cycles after the accept edge, and drive rsp_product = acc[2*WIDTH:1].
REQ-019 SHALL hold rsp_valid, rsp_product and rsp_id stable while rsp_valid & !rsp_ready.
REQ-020 SHALL keep the accept path closed in DONE; a new request is accepted one cycle after the response handshake at the earliest (no same-cycle re-accept).
REQ-021 SHALL ignore req inputs and operand changes while busy; latched operands alone determine the result.
REQ-022 SHALL keep rsp_product at its last value after the handshake until the next DONE entry.

Reset
REQ-023 SHALL on rst_n low immediately force IDLE, priority pointer 0, counter 0, accumulator 0, rsp_valid 0, rsp_id 0, rsp_product 0, busy 0, req0_ready and req1_ready 0, independent of clk.
REQ-024 SHALL abort any operation in RUN or DONE on reset with no response issued; the first accept after reset release is the first cycle rst_n is sampled high.

Structure
REQ-025 SHALL place the state enum (IDLE, RUN, DONE) and the Booth op encoding (NOP, ADD, SUB) in shared package booth_pkg.
REQ-026 SHALL implement the per-cycle add/subtract/arithmetic-shift as combinational sub-module booth_step (ports: acc_in, a_ext, acc_out; parameter WIDTH), instantiated once.
REQ-027 SHALL keep counter width $clog2(WIDTH+1) bits.

Verification
REQ-028 SHALL cover: req0 a=3, b=5, rsp_ready=1 -> rsp_valid exactly 32 cycles after accept, product 15, rsp_id 0.
REQ-029 SHALL cover: req1 a=-7, b=6 -> product 0xFFFF_FFFF_FFFF_FFD6 (-42), rsp_id 1.
REQ-030 SHALL cover: a=b=0x8000_0000 -> product 0x4000_0000_0000_0000; a=0x8000_0000, b=1 -> 0xFFFF_FFFF_8000_0000.
REQ-031 SHALL cover: both requesters valid continuously from reset -> accept order 0,1,0,1; lone req1 with pointer at 0 -> req1 accepted.
REQ-032 SHALL cover: rsp_ready low 10 cycles in DONE -> rsp_valid/product/id stable, req readies 0, then one handshake and return to IDLE.
REQ-033 SHALL cover: rst_n pulsed low at step 17 of RUN -> all outputs 0 asynchronously, no response, next request 2*3 completes normally with product 6.
